// File: rtl/skin_detect_ctrl_pkg.sv
// Shared types and constants for the skin-detection controller.
// Register map, mode encodings, FSM states and threshold defaults.
package skin_detect_ctrl_pkg;

  typedef enum logic [2:0] {
    ADDR_CB_MIN = 3'd0,
    ADDR_CB_MAX = 3'd1,
    ADDR_CR_MIN = 3'd2,
    ADDR_CR_MAX = 3'd3,
    ADDR_MODE   = 3'd4
  } addr_e;

  typedef enum logic [1:0] {
    MODE_MASK    = 2'd0,
    MODE_BYPASS  = 2'd1,
    MODE_OVERLAY = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] DEF_CB_MIN = 8'd77;
  localparam logic [7:0] DEF_CB_MAX = 8'd127;
  localparam logic [7:0] DEF_CR_MIN = 8'd133;
  localparam logic [7:0] DEF_CR_MAX = 8'd173;

  typedef struct packed {
    logic [7:0] cb_min;
    logic [7:0] cb_max;
    logic [7:0] cr_min;
    logic [7:0] cr_max;
    logic [1:0] mode;
  } thr_t;

  localparam thr_t THR_DEF = '{
    cb_min: DEF_CB_MIN,
    cb_max: DEF_CB_MAX,
    cr_min: DEF_CR_MIN,
    cr_max: DEF_CR_MAX,
    mode:   MODE_MASK
  };

  function automatic logic thr_ok(thr_t t);
    return (t.cb_min < t.cb_max) && (t.cr_min < t.cr_max);
  endfunction

endpackage

// File: rtl/skin_detect_ctrl_frame_edge_det.sv
// Frame-start edge detector: flags the cycle in which the sync
// input first enters its active level.
module frame_edge_det #(
  parameter logic VS_POL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsyn,
  output logic o_edge
);

  logic vs_q;

  // Reset to the active level so a sync held active through reset
  // is not mistaken for a fresh frame start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vs_q <= VS_POL;
    else          vs_q <= i_vsyn;
  end

  assign o_edge = (vs_q != VS_POL) && (i_vsyn == VS_POL);

endmodule

// File: rtl/skin_detect_ctrl.sv
// Frame-synchronous threshold staging and per-frame skin-pixel
// counting for the skin-colour detector.
module skin_detect_ctrl
  import skin_detect_ctrl_pkg::*;
#(
  parameter logic VS_POL = 1'b1,
  parameter int   CNT_W  = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_vsyn,
  input  logic             i_de,
  input  logic             i_skin_flag,
  input  logic             i_cfg_wr,
  input  logic [2:0]       i_cfg_addr,
  input  logic [7:0]       i_cfg_wdata,
  input  logic             i_cfg_commit,
  output logic [7:0]       o_cfg_rdata,
  output logic             o_cfg_pending,
  output logic             o_cfg_ack,
  output logic             o_cfg_err,
  output logic [7:0]       o_cb_min,
  output logic [7:0]       o_cb_max,
  output logic [7:0]       o_cr_min,
  output logic [7:0]       o_cr_max,
  output logic [1:0]       o_mode,
  output logic [CNT_W-1:0] o_skin_cnt,
  output logic             o_cnt_valid,
  output logic [15:0]      o_frame_cnt
);

  localparam logic [CNT_W-1:0] ACC_MAX = '1;
  localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);

  logic       edge_s;
  thr_t       stg_q, stg_w, act_q;
  logic       pend_q, pend_d;
  logic       ack_q, err_q;
  logic [7:0] rdata_q, rdata_d;
  logic       pix, xfer, cmt_ok;

  state_e     state_q, state_d;
  logic       cnt_en, report, acc_clr;

  logic [CNT_W-1:0] acc_q, acc_d, skin_q;
  logic             vld_q;
  logic [15:0]      frm_q;

  frame_edge_det #(.VS_POL(VS_POL)) u_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vsyn  (i_vsyn),
    .o_edge  (edge_s)
  );

  assign pix = i_de & i_skin_flag;

  // Staging view including a same-cycle write, used for validation.
  always_comb begin
    stg_w = stg_q;
    if (i_cfg_wr) begin
      case (i_cfg_addr)
        ADDR_CB_MIN: stg_w.cb_min = i_cfg_wdata;
        ADDR_CB_MAX: stg_w.cb_max = i_cfg_wdata;
        ADDR_CR_MIN: stg_w.cr_min = i_cfg_wdata;
        ADDR_CR_MAX: stg_w.cr_max = i_cfg_wdata;
        ADDR_MODE:   stg_w.mode   = i_cfg_wdata[1:0];
        default:     stg_w        = stg_q;
      endcase
    end
  end

  assign cmt_ok = i_cfg_commit & thr_ok(stg_w);
  assign xfer   = edge_s & pend_q;
  assign pend_d = cmt_ok | (pend_q & ~xfer);

  always_comb begin
    rdata_d = '0;
    case (i_cfg_addr)
      ADDR_CB_MIN: rdata_d = act_q.cb_min;
      ADDR_CB_MAX: rdata_d = act_q.cb_max;
      ADDR_CR_MIN: rdata_d = act_q.cr_min;
      ADDR_CR_MAX: rdata_d = act_q.cr_max;
      ADDR_MODE:   rdata_d = {6'd0, act_q.mode};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stg_q   <= THR_DEF;
      act_q   <= THR_DEF;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      stg_q   <= stg_w;
      if (xfer) act_q <= stg_q;
      pend_q  <= pend_d;
      ack_q   <= xfer;
      err_q   <= i_cfg_commit & ~cmt_ok;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_SYNC;
        S_SYNC:  if (edge_s) state_d = S_RUN;
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    report  = 1'b0;
    acc_clr = 1'b0;
    cnt_en  = 1'b0;
    if (!i_enable) begin
      acc_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_SYNC:  acc_clr = edge_s;
        S_RUN: begin
          report = edge_s;
          cnt_en = pix;
        end
        default: acc_clr = 1'b0;
      endcase
    end
  end

  // A pixel on the edge cycle belongs to the new frame.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr)
      acc_d = '0;
    else if (report)
      acc_d = cnt_en ? ACC_ONE : '0;
    else if (cnt_en && acc_q != ACC_MAX)
      acc_d = acc_q + ACC_ONE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q  <= '0;
      skin_q <= '0;
      vld_q  <= 1'b0;
      frm_q  <= '0;
    end else begin
      acc_q <= acc_d;
      vld_q <= report;
      if (report) begin
        skin_q <= acc_q;
        frm_q  <= frm_q + 16'd1;
      end
    end
  end

  assign o_cfg_rdata   = rdata_q;
  assign o_cfg_pending = pend_q;
  assign o_cfg_ack     = ack_q;
  assign o_cfg_err     = err_q;
  assign o_cb_min      = act_q.cb_min;
  assign o_cb_max      = act_q.cb_max;
  assign o_cr_min      = act_q.cr_min;
  assign o_cr_max      = act_q.cr_max;
  assign o_mode        = act_q.mode;
  assign o_skin_cnt    = skin_q;
  assign o_cnt_valid   = vld_q;
  assign o_frame_cnt   = frm_q;

endmodule

// File: tb/tb_skin_detect_ctrl.sv
// Self-checking bench for skin_detect_ctrl: directed scenarios plus
// randomized frames against a frame-level reference model.
module tb_skin_detect_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, vs = 1'b0, de = 1'b0, sf = 1'b0;
  logic wr = 1'b0, cmt = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wd = 8'd0;

  logic [7:0]  rdata, cbmn, cbmx, crmn, crmx;
  logic        pend, ack, err, vld;
  logic [1:0]  mode;
  logic [21:0] cnt;
  logic [15:0] frm;

  logic [7:0]  b_rdata, b_cbmn, b_cbmx, b_crmn, b_crmx;
  logic        b_pend, b_ack, b_err, b_vld;
  logic [1:0]  b_mode;
  logic [3:0]  b_cnt;
  logic [15:0] b_frm;

  int checks = 0;
  int errors = 0;

  int  stg_m[5] = '{77, 127, 133, 173, 0};
  int  act_m[5] = '{77, 127, 133, 173, 0};
  bit  pend_m = 1'b0;
  bit  xfer_m = 1'b0;
  int  exp_frm = 0;

  always #5 clk = ~clk;

  skin_detect_ctrl #(.VS_POL(1'b1), .CNT_W(22)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_vsyn(vs), .i_de(de), .i_skin_flag(sf),
    .i_cfg_wr(wr), .i_cfg_addr(addr), .i_cfg_wdata(wd),
    .i_cfg_commit(cmt), .o_cfg_rdata(rdata),
    .o_cfg_pending(pend), .o_cfg_ack(ack), .o_cfg_err(err),
    .o_cb_min(cbmn), .o_cb_max(cbmx), .o_cr_min(crmn),
    .o_cr_max(crmx), .o_mode(mode), .o_skin_cnt(cnt),
    .o_cnt_valid(vld), .o_frame_cnt(frm)
  );

  skin_detect_ctrl #(.VS_POL(1'b1), .CNT_W(4)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_vsyn(vs), .i_de(de), .i_skin_flag(sf),
    .i_cfg_wr(wr), .i_cfg_addr(addr), .i_cfg_wdata(wd),
    .i_cfg_commit(cmt), .o_cfg_rdata(b_rdata),
    .o_cfg_pending(b_pend), .o_cfg_ack(b_ack), .o_cfg_err(b_err),
    .o_cb_min(b_cbmn), .o_cb_max(b_cbmx), .o_cr_min(b_crmn),
    .o_cr_max(b_crmx), .o_mode(b_mode), .o_skin_cnt(b_cnt),
    .o_cnt_valid(b_vld), .o_frame_cnt(b_frm)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input int d);
    wr = 1'b1;
    addr = a[2:0];
    wd = d[7:0];
    tick();
    wr = 1'b0;
    if (a < 4) stg_m[a] = d;
    else if (a == 4) stg_m[4] = d & 3;
  endtask

  function automatic bit stg_valid();
    return (stg_m[0] < stg_m[1]) && (stg_m[2] < stg_m[3]);
  endfunction

  task automatic pix_run(input int n, output int nf);
    nf = 0;
    for (int i = 0; i < n; i++) begin
      de = ($urandom_range(0, 3) != 0);
      sf = $urandom_range(0, 1);
      if (de && sf) nf++;
      tick();
    end
    de = 1'b0;
    sf = 1'b0;
  endtask

  task automatic edge_cyc(input bit pe, input bit rep);
    vs = 1'b1;
    de = pe;
    sf = pe;
    tick();
    de = 1'b0;
    sf = 1'b0;
    if (rep) exp_frm++;
    xfer_m = pend_m;
    if (pend_m) begin
      for (int i = 0; i < 5; i++) act_m[i] = stg_m[i];
      pend_m = 1'b0;
    end
  endtask

  task automatic frame_gap();
    vs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int ra;
    #12;
    checks++; if (pend !== 1'b0) begin errors++;
      $display("FAIL rst_pend: got %b exp 0", pend); end
    checks++; if (rdata !== 8'd0) begin errors++;
      $display("FAIL rst_rdata: got %0d exp 0", rdata); end
    checks++; if (cnt !== 22'd0 || frm !== 16'd0) begin errors++;
      $display("FAIL rst_cnt: got %0d/%0d exp 0/0", cnt, frm); end
    checks++; if (vld !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_pulses: got %b%b%b exp 000",
                         vld, ack, err); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 6; a++) begin
      addr = a[2:0];
      tick();
      ra = (a < 5) ? act_m[a] : 0;
      checks++; if (rdata !== ra[7:0]) begin errors++;
        $display("FAIL rd_addr%0d: got %0d exp %0d", a, rdata, ra); end
    end
  endtask

  task automatic test_count();
    int nf;
    bit f[100];
    en = 1'b1;
    tick();
    pix_run(7, nf);
    edge_cyc(0, 0);
    checks++; if (vld !== 1'b0 || frm !== 16'd0) begin errors++;
      $display("FAIL first_edge: got vld %b frm %0d exp 0 0", vld, frm); end
    frame_gap();
    for (int i = 0; i < 100; i++) f[i] = (i < 37);
    for (int i = 99; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(i, 0);
      t = f[i]; f[i] = f[j]; f[j] = t;
    end
    for (int i = 0; i < 100; i++) begin
      de = 1'b1;
      sf = f[i];
      tick();
    end
    de = 1'b0; sf = 1'b0;
    edge_cyc(0, 1);
    checks++; if (cnt !== 22'd37 || vld !== 1'b1) begin errors++;
      $display("FAIL cnt37: got %0d vld %b exp 37 1", cnt, vld); end
    checks++; if (frm !== exp_frm[15:0]) begin errors++;
      $display("FAIL frm1: got %0d exp %0d", frm, exp_frm); end
    checks++; if (b_cnt !== 4'd15) begin errors++;
      $display("FAIL cnt37_sat: got %0d exp 15", b_cnt); end
    frame_gap();
    checks++; if (vld !== 1'b0) begin errors++;
      $display("FAIL vld_pulse: got %b exp 0", vld); end
  endtask

  task automatic test_commit();
    int nf;
    cfg_write(0, 90);
    cmt = 1'b1; tick(); cmt = 1'b0;
    pend_m = 1'b1;
    checks++; if (pend !== 1'b1 || cbmn !== 8'd77) begin errors++;
      $display("FAIL cmt_pend: got %b/%0d exp 1/77", pend, cbmn); end
    pix_run(8, nf);
    edge_cyc(0, 1);
    checks++; if (cbmn !== act_m[0][7:0] || ack !== xfer_m) begin
      errors++; $display("FAIL cmt_apply: got %0d ack %b exp %0d 1",
                         cbmn, ack, act_m[0]); end
    checks++; if (pend !== 1'b0) begin errors++;
      $display("FAIL cmt_clr: got %b exp 0", pend); end
    frame_gap();
    checks++; if (ack !== 1'b0) begin errors++;
      $display("FAIL ack_pulse: got %b exp 0", ack); end
    cfg_write(4, 2);
    cmt = 1'b1; tick(); tick(); cmt = 1'b0;
    pend_m = 1'b1;
    edge_cyc(0, 1);
    checks++; if (mode !== 2'd2 || ack !== 1'b1) begin errors++;
      $display("FAIL rep_cmt: got mode %0d ack %b exp 2 1", mode, ack); end
    frame_gap();
    edge_cyc(0, 1);
    checks++; if (ack !== 1'b0) begin errors++;
      $display("FAIL rep_ack2: got %b exp 0", ack); end
    frame_gap();
  endtask

  task automatic test_err();
    wr = 1'b1; addr = 3'd2; wd = 8'd180; cmt = 1'b1;
    tick();
    wr = 1'b0; cmt = 1'b0;
    stg_m[2] = 180;
    checks++; if (err !== 1'b1 || pend !== 1'b0) begin errors++;
      $display("FAIL err_pulse: got err %b pend %b exp 1 0", err, pend); end
    tick();
    checks++; if (err !== 1'b0) begin errors++;
      $display("FAIL err_once: got %b exp 0", err); end
    edge_cyc(0, 1);
    checks++; if (crmn !== 8'd133 || ack !== 1'b0) begin errors++;
      $display("FAIL err_noapply: got %0d ack %b exp 133 0", crmn, ack); end
    frame_gap();
    cfg_write(2, 133);
  endtask

  task automatic test_commit_at_edge();
    cfg_write(1, 200);
    vs = 1'b1; cmt = 1'b1;
    tick();
    cmt = 1'b0;
    exp_frm++;
    checks++; if (ack !== 1'b0 || pend !== 1'b1 || cbmx !== 8'd127) begin
      errors++; $display("FAIL edge_cmt: got ack %b pend %b cbmx %0d exp 0 1 127",
                         ack, pend, cbmx); end
    pend_m = stg_valid();
    frame_gap();
    cfg_write(1, 210);
    edge_cyc(0, 1);
    checks++; if (cbmx !== act_m[1][7:0] || ack !== 1'b1) begin errors++;
      $display("FAIL late_wr: got %0d ack %b exp %0d 1",
               cbmx, ack, act_m[1]); end
    frame_gap();
  endtask

  task automatic test_saturate();
    int nf;
    for (int i = 0; i < 20; i++) begin
      de = 1'b1; sf = 1'b1; tick();
    end
    de = 1'b0; sf = 1'b0;
    edge_cyc(0, 1);
    checks++; if (b_cnt !== 4'd15 || cnt !== 22'd20) begin errors++;
      $display("FAIL sat: got %0d/%0d exp 15/20", b_cnt, cnt); end
    checks++; if (frm !== exp_frm[15:0]) begin errors++;
      $display("FAIL sat_frm: got %0d exp %0d", frm, exp_frm); end
    frame_gap();
    pix_run(5, nf);
    en = 1'b0;
    pix_run(5, nf);
    edge_cyc(1, 0);
    checks++; if (vld !== 1'b0 || cnt !== 22'd20) begin errors++;
      $display("FAIL dis_nrep: got vld %b cnt %0d exp 0 20", vld, cnt); end
    checks++; if (frm !== exp_frm[15:0]) begin errors++;
      $display("FAIL dis_frm: got %0d exp %0d", frm, exp_frm); end
    frame_gap();
  endtask

  task automatic test_random();
    int nf, n, exp_c, carry, sat;
    bit pe, ok;
    en = 1'b1;
    tick();
    pix_run(5, nf);
    edge_cyc(1, 0);
    frame_gap();
    carry = 0;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int a = 0; a < 4; a++) cfg_write(a, $urandom_range(0, 255));
        cmt = 1'b1; tick(); cmt = 1'b0;
        ok = stg_valid();
        if (ok) pend_m = 1'b1;
        checks++; if (err !== !ok || pend !== pend_m) begin errors++;
          $display("FAIL rnd_cmt%0d: got err %b pend %b exp %b %b",
                   k, err, pend, !ok, pend_m); end
      end
      n = $urandom_range(10, 60);
      pix_run(n, nf);
      exp_c = carry + nf;
      sat = (exp_c > 15) ? 15 : exp_c;
      pe = $urandom_range(0, 1);
      edge_cyc(pe, 1);
      checks++; if (cnt !== exp_c || b_cnt !== sat[3:0]) begin errors++;
        $display("FAIL rnd_cnt%0d: got %0d/%0d exp %0d/%0d",
                 k, cnt, b_cnt, exp_c, sat); end
      checks++; if (vld !== 1'b1 || frm !== exp_frm[15:0]) begin errors++;
        $display("FAIL rnd_frm%0d: got vld %b frm %0d exp 1 %0d",
                 k, vld, frm, exp_frm); end
      checks++; if (ack !== xfer_m || cbmn !== act_m[0][7:0] ||
                    cbmx !== act_m[1][7:0] || crmn !== act_m[2][7:0] ||
                    crmx !== act_m[3][7:0]) begin errors++;
        $display("FAIL rnd_act%0d: got %b %0d %0d %0d %0d exp %b %0d %0d %0d %0d",
                 k, ack, cbmn, cbmx, crmn, crmx,
                 xfer_m, act_m[0], act_m[1], act_m[2], act_m[3]); end
      carry = pe;
      frame_gap();
    end
  endtask

  task automatic test_reset_mid();
    int nf;
    cfg_write(0, 60); cfg_write(1, 100);
    cfg_write(2, 140); cfg_write(3, 170);
    cmt = 1'b1; tick(); cmt = 1'b0;
    checks++; if (pend !== 1'b1) begin errors++;
      $display("FAIL rm_pend: got %b exp 1", pend); end
    pix_run(4, nf);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pend !== 1'b0 || cbmn !== 8'd77 || frm !== 16'd0 ||
                  cnt !== 22'd0 || mode !== 2'd0) begin errors++;
      $display("FAIL rm_async: got %b %0d %0d %0d %0d exp 0 77 0 0 0",
               pend, cbmn, frm, cnt, mode); end
    @(negedge clk);
    rst_n = 1'b1;
    stg_m = '{77, 127, 133, 173, 0};
    act_m = '{77, 127, 133, 173, 0};
    pend_m = 1'b0;
    exp_frm = 0;
    tick();
    edge_cyc(0, 0);
    checks++; if (ack !== 1'b0 || cbmn !== 8'd77 || vld !== 1'b0) begin
      errors++; $display("FAIL rm_lost: got ack %b cbmn %0d vld %b exp 0 77 0",
                         ack, cbmn, vld); end
    frame_gap();
  endtask

  initial begin
    test_reset();
    test_count();
    test_commit();
    test_err();
    test_commit_at_edge();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
